id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage that consumes the fetch stage's `PC`/`Instruction` pair. It latches the pair in an IF/ID register and decodes the opcode. It reads a 32×32 register file that the write-back stage writes, and registers operands and control into an ID/EX register. Branch resolution happens here: `br_taken`/`br_target` feed back to fetch to redirect the PC, and the wrong-path instruction already fetched is squashed.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h0000_0000: instruction word loaded on flush/reset (opcode 0 = NOP).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `if_pc`  in  32  PC of instruction presented by fetch
- `if_instruction`  in  32  instruction word from fetch
- `freeze`  in  1  hazard stall: hold IF/ID, bubble ID/EX
- `wb_en`  in  1  register-file write enable from write-back
- `wb_dest`  in  5  write-back register index
- `wb_value`  in  32  write-back data
- `br_taken`  out  1  combinational redirect request to fetch
- `br_target`  out  32  combinational redirect address
- `id_src1`, `id_src2`  out  5  source indices for hazard unit
- `id_two_src`  out  1  instruction reads `id_src2`
- `ex_pc`  out  32  PC of instruction in ID/EX
- `ex_cmd`  out  4  ALU command
- `ex_val1`, `ex_val2`  out  32  ALU operands
- `ex_st_val`  out  32  store data
- `ex_dest`  out  5  destination index
- `ex_wb_en`, `ex_mem_r_en`, `ex_mem_w_en`  out  1  control

## Operation
- Fields: opcode [31:26], rs1 [25:21]. R-type: rs2 [20:16], rd [15:11]. I-type/LD: rd [20:16], imm [15:0], sign-extended to 32 bits. ST/BNE: second source [20:16].
- Opcode map → `ex_cmd`:
  - 0 NOP → 0
  - 1 ADD, 32 ADDI, 36 LD, 37 ST → 1
  - 3 SUB, 33 SUBI → 2
  - 5 AND → 3; 6 OR → 4; 7 NOR → 5; 8 XOR → 6
  - 9 SLA, 10 SLL → 7; 11 SRA → 8; 12 SRL → 9
  - 40 BEZ, 41 BNE, 42 JMP → 0
  - Any other opcode decodes as NOP (all enables 0).
- `ex_wb_en` = 1 for R-type, ADDI, SUBI, LD. `ex_mem_r_en` = LD. `ex_mem_w_en` = ST.
- Operands and destination:
  - `ex_val2` = reg[rs2] for R-type, else the sign-extended immediate.
  - `ex_st_val` = reg[[20:16]].
  - `ex_dest` = rd; 0 for ST, branches and NOP.
- Source reporting: `id_two_src` = 1 for R-type, ST, BNE. `id_src2` = [20:16] for ST/BNE, rs2 for R-type. Both index outputs are 0 for NOP.
- Register file:
  - 32 entries, reset to 0; r0 reads 0 and ignores writes.
  - Writes occur at the rising edge when `wb_en`=1.
  - Reads are combinational with write-through: if `wb_en` and `wb_dest`==read index≠0, return `wb_value`.
- Branch resolution, from IF/ID contents:
  - BEZ taken iff reg[rs1]==0.
  - BNE taken iff reg[rs1]!=reg[[20:16]].
  - JMP always taken.
  - `br_target` = id_pc + 4 + (sext(imm) << 2), modulo 2^32.
  - `br_taken` is forced 0 while `freeze`=1.
- IF/ID register update:
  - Priority rst > freeze (hold) > br_taken (load `NOP_INSTR`, pc 0) > normal load of `if_pc`/`if_instruction`.
- ID/EX register update:
  - rst → all zero.
  - freeze → bubble (all control 0, `ex_cmd` 0, data 0).
  - Otherwise load the decoded values.

## Timing
- Reset: asynchronous, takes effect immediately. All `ex_*` outputs are 0, IF/ID holds NOP, and `br_taken`=0, `br_target`=4, `id_two_src`=0, `id_src1`/`id_src2`=0.
- Latency: instruction on `if_*` at edge k enters IF/ID. Its decode appears on `ex_*` after edge k+1. Two edges in total.
- `br_taken`/`br_target` are valid in the same cycle the branch sits in IF/ID. Fetch samples them at the next edge; at that edge the wrong-path instruction is replaced by NOP. The branch itself flows to ID/EX as NOP-class (no enables).
- Freeze: IF/ID holds for as many cycles as `freeze` stays high. One bubble per frozen cycle enters ID/EX. A pending branch resolves on the first unfrozen cycle.
- Write-back at the same edge as an ID read: the bypass guarantees the new value is used.
- Simultaneous freeze and branch: freeze wins, no redirect.
- `rst` asserted mid-stream: every register clears asynchronously, with no partial state.

## Test plan
- Reset → all `ex_*` 0, `br_taken`=0, `br_target`=4, IF/ID NOP. Then present ADDI r1,r0,#0x060A (32'h8001060A) → two edges later `ex_cmd`=1, `ex_val2`=0x060A, `ex_dest`=1, `ex_wb_en`=1.
- WB writes r1=5, r2=7, then present ADD r3,r1,r2 (rs1=1, rs2=2, rd=3) → `ex_val1`=5, `ex_val2`=7, `ex_dest`=3. Repeat with the r2 write in the decode cycle to confirm bypass.
- BEZ r5,+1 at pc 0x34 with r5=0 → `br_taken`=1, `br_target`=0x3C. Next IF/ID is NOP, and `ex_*` shows no enables for the squashed slot. With r5=3 → `br_taken`=0.
- JMP imm 0xFFFF at pc 0x100 → `br_target`=0x100. BNE r1,r3,−15 at pc 0xC0, r1≠r3 → `br_target`=0x88.
- `freeze`=1 for 2 cycles with BEZ taken in IF/ID → `br_taken`=0, IF/ID unchanged, 2 bubbles out. Release → `br_taken`=1.
- WB writes r0=0xFFFF → r0 still reads 0. Opcode 63 → decoded as NOP. `rst` pulsed mid-stream → immediate clear.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with
// write-through reads, opcode decode, branch resolution and ID/EX register.
// Ports:
//   clk, rst                    clock, async active-high reset
//   if_pc, if_instruction       PC/instruction pair from fetch
//   freeze                      hazard stall (hold IF/ID, bubble ID/EX)
//   wb_en, wb_dest, wb_value    register-file write port from write-back
//   br_taken, br_target         combinational redirect to fetch
//   id_src1, id_src2, id_two_src  source indices for the hazard unit
//   ex_*                        registered ID/EX payload
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instruction,
   input  logic        freeze,
   input  logic        wb_en,
   input  logic [4:0]  wb_dest,
   input  logic [31:0] wb_value,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic [4:0]  id_src1,
   output logic [4:0]  id_src2,
   output logic        id_two_src,
   output logic [31:0] ex_pc,
   output logic [3:0]  ex_cmd,
   output logic [31:0] ex_val1,
   output logic [31:0] ex_val2,
   output logic [31:0] ex_st_val,
   output logic [4:0]  ex_dest,
   output logic        ex_wb_en,
   output logic        ex_mem_r_en,
   output logic        ex_mem_w_en
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RIDX  = 5;
   localparam int unsigned NREGS = 32;

   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] rf [NREGS];

   logic [5:0]      opcode;
   logic [RIDX-1:0] rs1;
   logic [RIDX-1:0] rt;
   logic [RIDX-1:0] rd;
   logic [XLEN-1:0] sext_imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rt_val;

   logic [3:0] dec_cmd;
   logic       is_r, is_imm, is_ld, is_st, is_bez, is_bne, is_jmp;
   logic       is_valid;
   logic       br_cond;

   assign opcode   = id_instr[31:26];
   assign rs1      = id_instr[25:21];
   assign rt       = id_instr[20:16];
   assign rd       = id_instr[15:11];
   assign sext_imm = {{16{id_instr[15]}}, id_instr[15:0]};

   // Register file; r0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
      end else if (wb_en && (wb_dest != '0)) begin
         rf[wb_dest] <= wb_value;
      end
   end

   // Write-through reads so a same-edge write-back is seen by decode.
   assign rs1_val = (rs1 == '0) ? '0 :
                    (wb_en && (wb_dest == rs1)) ? wb_value : rf[rs1];
   assign rt_val  = (rt == '0) ? '0 :
                    (wb_en && (wb_dest == rt)) ? wb_value : rf[rt];

   // Opcode decode; unknown opcodes fall through as NOP.
   always_comb begin
      dec_cmd = 4'd0;
      is_r    = 1'b0;
      is_imm  = 1'b0;
      is_ld   = 1'b0;
      is_st   = 1'b0;
      is_bez  = 1'b0;
      is_bne  = 1'b0;
      is_jmp  = 1'b0;
      case (opcode)
         6'd1:         begin dec_cmd = 4'd1; is_r = 1'b1; end
         6'd3:         begin dec_cmd = 4'd2; is_r = 1'b1; end
         6'd5:         begin dec_cmd = 4'd3; is_r = 1'b1; end
         6'd6:         begin dec_cmd = 4'd4; is_r = 1'b1; end
         6'd7:         begin dec_cmd = 4'd5; is_r = 1'b1; end
         6'd8:         begin dec_cmd = 4'd6; is_r = 1'b1; end
         6'd9, 6'd10:  begin dec_cmd = 4'd7; is_r = 1'b1; end
         6'd11:        begin dec_cmd = 4'd8; is_r = 1'b1; end
         6'd12:        begin dec_cmd = 4'd9; is_r = 1'b1; end
         6'd32:        begin dec_cmd = 4'd1; is_imm = 1'b1; end
         6'd33:        begin dec_cmd = 4'd2; is_imm = 1'b1; end
         6'd36:        begin dec_cmd = 4'd1; is_ld = 1'b1; end
         6'd37:        begin dec_cmd = 4'd1; is_st = 1'b1; end
         6'd40:        is_bez = 1'b1;
         6'd41:        is_bne = 1'b1;
         6'd42:        is_jmp = 1'b1;
         default:      ;
      endcase
   end

   assign is_valid   = is_r | is_imm | is_ld | is_st | is_bez | is_bne | is_jmp;
   assign id_two_src = is_r | is_st | is_bne;
   assign id_src1    = is_valid ? rs1 : '0;
   assign id_src2    = id_two_src ? rt : '0;

   assign br_cond   = (is_bez && (rs1_val == '0)) ||
                      (is_bne && (rs1_val != rt_val)) ||
                      is_jmp;
   assign br_taken  = br_cond && !freeze;
   assign br_target = id_pc + 32'd4 + {sext_imm[XLEN-3:0], 2'b00};

   // IF/ID: hold on freeze, squash the wrong-path fetch on a taken branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc    <= '0;
         id_instr <= NOP_INSTR;
      end else if (freeze) begin
         id_pc    <= id_pc;
         id_instr <= id_instr;
      end else if (br_taken) begin
         id_pc    <= '0;
         id_instr <= NOP_INSTR;
      end else begin
         id_pc    <= if_pc;
         id_instr <= if_instruction;
      end
   end

   // ID/EX: freeze inserts an all-zero bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || freeze) begin
         ex_pc       <= '0;
         ex_cmd      <= '0;
         ex_val1     <= '0;
         ex_val2     <= '0;
         ex_st_val   <= '0;
         ex_dest     <= '0;
         ex_wb_en    <= 1'b0;
         ex_mem_r_en <= 1'b0;
         ex_mem_w_en <= 1'b0;
      end else begin
         ex_pc       <= id_pc;
         ex_cmd      <= dec_cmd;
         ex_val1     <= rs1_val;
         ex_val2     <= is_r ? rt_val : sext_imm;
         ex_st_val   <= rt_val;
         ex_dest     <= is_r ? rd : ((is_imm || is_ld) ? rt : '0);
         ex_wb_en    <= is_r | is_imm | is_ld;
         ex_mem_r_en <= is_ld;
         ex_mem_w_en <= is_st;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc, if_instruction;
   logic        freeze, wb_en;
   logic [4:0]  wb_dest;
   logic [31:0] wb_value;
   logic        br_taken;
   logic [31:0] br_target;
   logic [4:0]  id_src1, id_src2;
   logic        id_two_src;
   logic [31:0] ex_pc;
   logic [3:0]  ex_cmd;
   logic [31:0] ex_val1, ex_val2, ex_st_val;
   logic [4:0]  ex_dest;
   logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
      .freeze(freeze), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
      .br_taken(br_taken), .br_target(br_target), .id_src1(id_src1),
      .id_src2(id_src2), .id_two_src(id_two_src), .ex_pc(ex_pc),
      .ex_cmd(ex_cmd), .ex_val1(ex_val1), .ex_val2(ex_val2),
      .ex_st_val(ex_st_val), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
      .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en)
   );

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  cmd;
      logic [31:0] v1, v2, st;
      logic [4:0]  dest;
      logic        wb, mr, mw;
   } ex_t;

   localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4,
                  K_BEZ = 5, K_BNE = 6, K_JMP = 7;

   // Model state: architectural registers, the instruction held in decode,
   // and the payload that must be visible on ex_*.
   logic [31:0] mreg [32];
   logic [31:0] m_pc, m_ins;
   ex_t         m_ex;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int kind_of(input logic [5:0] op);
      case (op)
         6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: return K_R;
         6'd32, 6'd33: return K_I;
         6'd36: return K_LD;
         6'd37: return K_ST;
         6'd40: return K_BEZ;
         6'd41: return K_BNE;
         6'd42: return K_JMP;
         default: return K_NOP;
      endcase
   endfunction

   function automatic logic [3:0] cmd_of(input logic [5:0] op);
      case (op)
         6'd1, 6'd32, 6'd36, 6'd37: return 4'd1;
         6'd3, 6'd33: return 4'd2;
         6'd5: return 4'd3;
         6'd6: return 4'd4;
         6'd7: return 4'd5;
         6'd8: return 4'd6;
         6'd9, 6'd10: return 4'd7;
         6'd11: return 4'd8;
         6'd12: return 4'd9;
         default: return 4'd0;
      endcase
   endfunction

   // Architectural read as seen by decode this cycle (includes write-back).
   function automatic logic [31:0] rdreg(input logic [4:0] i);
      if (i == 5'd0) return 32'd0;
      if (wb_en && wb_dest == i) return wb_value;
      return mreg[i];
   endfunction

   function automatic logic [31:0] sx(input logic [15:0] imm);
      return 32'($signed(imm));
   endfunction

   function automatic logic exp_taken();
      int k = kind_of(m_ins[31:26]);
      logic a, b;
      a = (k == K_BEZ) && (rdreg(m_ins[25:21]) == 32'd0);
      b = (k == K_BNE) && (rdreg(m_ins[25:21]) != rdreg(m_ins[20:16]));
      return !freeze && (a || b || k == K_JMP);
   endfunction

   function automatic ex_t exp_decode();
      ex_t e;
      int k = kind_of(m_ins[31:26]);
      e.pc   = m_pc;
      e.cmd  = cmd_of(m_ins[31:26]);
      e.v1   = rdreg(m_ins[25:21]);
      e.v2   = (k == K_R) ? rdreg(m_ins[20:16]) : sx(m_ins[15:0]);
      e.st   = rdreg(m_ins[20:16]);
      e.dest = (k == K_R) ? m_ins[15:11] : ((k == K_I || k == K_LD) ? m_ins[20:16] : 5'd0);
      e.wb   = (k == K_R || k == K_I || k == K_LD);
      e.mr   = (k == K_LD);
      e.mw   = (k == K_ST);
      return e;
   endfunction

   function automatic ex_t ex_zero();
      ex_t e;
      e.pc = '0; e.cmd = '0; e.v1 = '0; e.v2 = '0; e.st = '0;
      e.dest = '0; e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
      return e;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      m_pc  = '0;
      m_ins = 32'h0;
      m_ex  = ex_zero();
   endtask

   task automatic compare_all();
      int  k   = kind_of(m_ins[31:26]);
      logic two = (k == K_R || k == K_ST || k == K_BNE);
      chk("br_taken", 32'(br_taken), 32'(exp_taken()));
      chk("br_target", br_target, m_pc + 32'd4 + (sx(m_ins[15:0]) << 2));
      chk("id_two_src", 32'(id_two_src), 32'(two));
      chk("id_src1", 32'(id_src1), (k == K_NOP) ? 32'd0 : 32'(m_ins[25:21]));
      chk("id_src2", 32'(id_src2), two ? 32'(m_ins[20:16]) : 32'd0);
      chk("ex_pc", ex_pc, m_ex.pc);
      chk("ex_cmd", 32'(ex_cmd), 32'(m_ex.cmd));
      chk("ex_val1", ex_val1, m_ex.v1);
      chk("ex_val2", ex_val2, m_ex.v2);
      chk("ex_st_val", ex_st_val, m_ex.st);
      chk("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
      chk("ex_wb_en", 32'(ex_wb_en), 32'(m_ex.wb));
      chk("ex_mem_r_en", 32'(ex_mem_r_en), 32'(m_ex.mr));
      chk("ex_mem_w_en", 32'(ex_mem_w_en), 32'(m_ex.mw));
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic frz,
                        input logic we, input logic [4:0] wd, input logic [31:0] wv);
      if_pc = pc; if_instruction = ins; freeze = frz;
      wb_en = we; wb_dest = wd; wb_value = wv;
   endtask

   // One clock: compare at the falling edge, advance the model across the
   // rising edge, leave time at posedge+1 for the next drive.
   task automatic tick();
      ex_t         nx_ex;
      logic [31:0] nx_pc, nx_ins;
      logic        do_wr;
      @(negedge clk);
      compare_all();
      nx_ex = m_ex; nx_pc = m_pc; nx_ins = m_ins;
      do_wr = wb_en && wb_dest != 5'd0;
      if (!rst) begin
         if (freeze) nx_ex = ex_zero();
         else begin
            nx_ex = exp_decode();
            if (exp_taken()) begin nx_pc = '0; nx_ins = 32'h0; end
            else begin nx_pc = if_pc; nx_ins = if_instruction; end
         end
      end
      @(posedge clk);
      #1;
      if (rst) m_reset();
      else begin
         if (do_wr) mreg[wb_dest] = wb_value;
         m_ex = nx_ex; m_pc = nx_pc; m_ins = nx_ins;
      end
   endtask

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] ADDI  = 32'h8001_060A;
   localparam logic [31:0] ADD   = 32'h0422_1800;
   localparam logic [31:0] BEZ5  = 32'hA0A0_0001;
   localparam logic [31:0] BEZ6  = 32'hA0C0_0001;
   localparam logic [31:0] BEZ0  = 32'hA000_0001;
   localparam logic [31:0] JMP   = 32'hA800_FFFF;
   localparam logic [31:0] BNE   = 32'hA423_FFF1;
   localparam logic [31:0] BAD   = 32'hFC22_1800;

   int ops [21] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 63, 2, 50};

   initial begin
      logic [31:0] ins;
      rst = 1'b1;
      drive(0, NOP, 0, 0, 0, 0);
      m_reset();
      #1;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst ex_cmd", 32'(ex_cmd), 32'd0);
      chk("rst ex_wb_en", 32'(ex_wb_en), 32'd0);
      chk("rst br_taken", 32'(br_taken), 32'd0);
      chk("rst br_target", br_target, 32'd4);

      // ADDI r1,r0,#0x060A
      drive(32'h10, ADDI, 0, 0, 0, 0); tick();
      drive(32'h14, NOP, 0, 0, 0, 0); tick();
      chk("addi cmd", 32'(ex_cmd), 32'd1);
      chk("addi val2", ex_val2, 32'h060A);
      chk("addi dest", 32'(ex_dest), 32'd1);
      chk("addi wb_en", 32'(ex_wb_en), 32'd1);

      // ADD r3,r1,r2 after write-back of r1, r2
      drive(0, NOP, 0, 1, 5'd1, 32'd5); tick();
      drive(0, NOP, 0, 1, 5'd2, 32'd7); tick();
      drive(32'h20, ADD, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 0, 0, 0); tick();
      chk("add val1", ex_val1, 32'd5);
      chk("add val2", ex_val2, 32'd7);
      chk("add dest", 32'(ex_dest), 32'd3);

      // Same ADD with r2 written in its decode cycle
      drive(32'h24, ADD, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 1, 5'd2, 32'd9); tick();
      chk("bypass val2", ex_val2, 32'd9);

      // BEZ r5 taken, wrong-path ADDI squashed
      drive(32'h34, BEZ5, 0, 0, 0, 0); tick();
      drive(32'h38, ADDI, 0, 0, 0, 0); #1;
      chk("bez taken", 32'(br_taken), 32'd1);
      chk("bez target", br_target, 32'h3C);
      tick();
      chk("bez ex_wb_en", 32'(ex_wb_en), 32'd0);
      drive(32'h3C, NOP, 0, 0, 0, 0); tick();
      chk("squash ex_wb_en", 32'(ex_wb_en), 32'd0);
      chk("squash ex_dest", 32'(ex_dest), 32'd0);

      // JMP and BNE targets
      drive(32'h100, JMP, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 0, 0, 0); #1;
      chk("jmp target", br_target, 32'h100);
      tick();
      drive(32'hC0, BNE, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 0, 0, 0); #1;
      chk("bne taken", 32'(br_taken), 32'd1);
      chk("bne target", br_target, 32'h88);
      tick();

      // Freeze two cycles with a taken BEZ in decode
      drive(32'h30, ADDI, 0, 0, 0, 0); tick();
      drive(32'h34, BEZ6, 0, 0, 0, 0); tick();
      drive(32'h38, ADDI, 1, 0, 0, 0); #1;
      chk("frz1 br_taken", 32'(br_taken), 32'd0);
      tick();
      chk("frz1 bubble", 32'(ex_wb_en), 32'd0);
      #1;
      chk("frz2 br_taken", 32'(br_taken), 32'd0);
      tick();
      chk("frz2 bubble", 32'(ex_cmd), 32'd0);
      drive(32'h38, ADDI, 0, 0, 0, 0); #1;
      chk("unfrz br_taken", 32'(br_taken), 32'd1);
      chk("unfrz target", br_target, 32'h3C);
      tick();

      // BEZ r5 not taken once r5=3
      drive(0, NOP, 0, 1, 5'd5, 32'd3); tick();
      drive(32'h34, BEZ5, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 0, 0, 0); #1;
      chk("bez nt", 32'(br_taken), 32'd0);
      tick();

      // r0 stays zero, with and without a same-cycle write
      drive(0, NOP, 0, 1, 5'd0, 32'hFFFF); tick();
      drive(32'h40, BEZ0, 0, 1, 5'd0, 32'hFFFF); tick();
      drive(0, NOP, 0, 1, 5'd0, 32'hFFFF); #1;
      chk("r0 zero", 32'(br_taken), 32'd1);
      tick();

      // Undefined opcode
      drive(32'h50, BAD, 0, 0, 0, 0); tick();
      drive(0, NOP, 0, 0, 0, 0); tick();
      chk("op63 wb_en", 32'(ex_wb_en), 32'd0);
      chk("op63 dest", 32'(ex_dest), 32'd0);

      // Randomized traffic with one mid-stream reset pulse
      for (int c = 0; c < 600; c++) begin
         ins = {6'(ops[$urandom_range(0, 20)]), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
         drive({$urandom, 2'b00} & 32'h0000_FFFC, ins, ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
         if (c == 300) begin
            rst = 1'b1;
            #1;
            chk("async rst ex_cmd", 32'(ex_cmd), 32'd0);
            chk("async rst ex_wb_en", 32'(ex_wb_en), 32'd0);
            chk("async rst br_target", br_target, 32'd4);
            m_reset();
            tick();
            rst = 1'b0;
         end else begin
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
